// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding an 8N1 UART serializer.
// The core pushes bytes with single-cycle strobes. The serializer drains the
// FIFO and sends queued frames back to back, with no idle gap between them.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  output logic                         full,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         overflow,
  output logic                         TXD
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    shift;
  logic [15:0]    baud_cnt;
  logic [2:0]    bit_idx;
  logic          push;
  logic          pop;

  // full comes from the registered count, so a pop in the same cycle does
  // not make room for a push.
  assign full = (count == CW'(FIFO_DEPTH));
  assign push = wr_en && !full;

  // The head byte leaves the FIFO when the serializer starts a frame: either
  // from IDLE, or at the end of a stop bit when another byte is waiting.
  assign pop  = (count != '0) &&
                ((state == IDLE) || ((state == STOP) && (baud_cnt == '0)));

  assign busy = (count != '0) || (state != IDLE);

  // FIFO bookkeeping: pointers, fill level and the sticky overflow flag.
  // NOTE: registered state is always assigned with <=, so every always_ff
  // samples the pre-edge values of the other registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset. Only the pointers and the count
  // define which entries are valid, so clearing the array would add logic
  // without changing behaviour.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= wr_data;
  end

  // Serializer FSM. TXD is registered from the current state, so the line
  // follows the state by one cycle. Every frame shows exactly 10 bit periods.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      TXD      <= 1'b1;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          TXD <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= BAUD_MAX;
            state    <= START;
          end
        end
        START: begin
          TXD <= 1'b0;
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_MAX;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          TXD <= shift[0];
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_MAX;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          TXD <= 1'b1;
          if (baud_cnt == '0) begin
            if (pop) begin
              shift    <= mem[rd_ptr];
              baud_cnt <= BAUD_MAX;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          TXD   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Accepted bytes go into a queue. A bench UART receiver samples TXD at mid-bit
// and pops the queue to compare each frame it decodes.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       busy;
  logic [3:0] count;
  logic       overflow;
  logic       txd;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .busy     (busy),
    .count    (count),
    .overflow (overflow),
    .TXD      (txd)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] sb[$];
  int         starts[$];
  int         frames_rx = 0;
  logic       rx_busy = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bench UART receiver. The start bit is detected on its first low sample;
  // every later bit is sampled in the middle of its bit period.
  always @(negedge clk) begin
    if (reset) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (txd == 1'b0) begin
        rx_busy <= 1'b1;
        rx_t    <= 1;
        starts.push_back(cyc);
      end
    end else begin
      rx_t <= rx_t + 1;
      if (rx_t == CPB / 2) begin
        check("rx_start_bit", 32'(txd), 32'd0);
      end else if (rx_t > CPB / 2 && rx_t < CPB / 2 + 9 * CPB && ((rx_t - CPB / 2) % CPB) == 0) begin
        rx_byte[3'((rx_t - CPB / 2) / CPB - 1)] <= txd;
      end else if (rx_t == CPB / 2 + 9 * CPB) begin
        check("rx_stop_bit", 32'(txd), 32'd1);
        frames_rx <= frames_rx + 1;
        check("rx_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("rx_data", 32'(rx_byte), 32'(sb[0]));
          void'(sb.pop_front());
        end
      end else if (rx_t == FRAME - 1) begin
        rx_busy <= 1'b0;
      end
    end
  end

  task automatic wait_drain(input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (!busy && !rx_busy) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_gaps(input int n);
    check("frame_count", 32'(starts.size()), 32'(n));
    for (int i = 1; i < starts.size(); i++)
      check("frame_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));
  endtask

  task automatic write_burst(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      wr_en   = 1'b1;
      wr_data = bytes[i];
      sb.push_back(bytes[i]);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       exp_bit;
    int         snap;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x55: exact waveform, 4 cycles per bit, start 2 edges after the write
    d = 8'h55;
    starts.delete();
    wr_en = 1'b1; wr_data = d; sb.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k < 2 || k > 41) exp_bit = 1'b1;
      else if ((k - 2) / CPB == 0) exp_bit = 1'b0;
      else if ((k - 2) / CPB == 9) exp_bit = 1'b1;
      else exp_bit = d[3'((k - 2) / CPB - 1)];
      check($sformatf("wave55_k%0d", k), 32'(txd), 32'(exp_bit));
      if (k == 1)  check("busy_after_write", 32'(busy), 32'd1);
      if (k >= 41) check("busy_after_frame", 32'(busy), 32'd0);
    end
    wait_drain(100);
    check_gaps(1);

    // Back-to-back frames 0xA5, 0x3C
    starts.delete();
    write_burst('{8'hA5, 8'h3C});
    wait_drain(200);
    check_gaps(2);

    // Fill to full, overflow on the 10th write, 9 frames sent in order
    starts.delete();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h10 + i * 8'h11);
      if (i < 9) sb.push_back(wr_data);
      @(negedge clk);
      if (i == 8) begin
        check("count_at_full", 32'(count), 32'(DEPTH));
        check("full_set", 32'(full), 32'd1);
        check("overflow_before_drop", 32'(overflow), 32'd0);
      end
      if (i == 9) begin
        check("count_after_drop", 32'(count), 32'(DEPTH));
        check("overflow_set", 32'(overflow), 32'd1);
      end
    end
    wr_en = 1'b0;
    wait_drain(600);
    check_gaps(9);
    check("overflow_sticky", 32'(overflow), 32'd1);
    check("full_cleared", 32'(full), 32'd0);

    // Push on the exact edge where STOP pops the next byte
    starts.delete();
    write_burst('{8'h81, 8'h7E});
    repeat (39) @(negedge clk);
    check("count_before_simul", 32'(count), 32'd1);
    wr_en = 1'b1; wr_data = 8'hC3; sb.push_back(8'hC3);
    @(negedge clk);
    wr_en = 1'b0;
    check("count_after_simul", 32'(count), 32'd1);
    wait_drain(300);
    check_gaps(3);

    // Reset during DATA bit 3 with 3 bytes queued; wr_en held during reset
    write_burst('{8'h11, 8'h22, 8'h33, 8'h44});
    repeat (15) @(negedge clk);
    check("overflow_pre_reset", 32'(overflow), 32'd1);
    check("count_pre_reset", 32'(count), 32'd3);
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    sb.delete();
    @(negedge clk);
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    snap = frames_rx;
    starts.delete();
    repeat (100) @(negedge clk);
    check("no_frames_after_reset", 32'(frames_rx), 32'(snap));
    check("no_starts_after_reset", 32'(starts.size()), 32'd0);
    check("idle_txd_after_reset", 32'(txd), 32'd1);
    check("idle_busy_after_reset", 32'(busy), 32'd0);

    // Wrap-around: 20 random bytes in bursts of 4
    snap = frames_rx;
    for (int b = 0; b < 5; b++) begin
      logic [7:0] burst[$];
      burst.delete();
      for (int j = 0; j < 4; j++) burst.push_back(8'($urandom_range(0, 255)));
      write_burst(burst);
      repeat (160) @(negedge clk);
    end
    wait_drain(1000);
    check("wrap_frames", 32'(frames_rx - snap), 32'd20);
    check("wrap_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning transmit FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1, one-cycle store strobe from the core IO page (UART data word).
REQ-006 SHALL have port wr_data, input, 8, byte to transmit, sampled when wr_en=1.
REQ-007 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-008 SHALL have port busy, output, 1, FIFO non-empty or frame in progress (core-readable status bit).
REQ-009 SHALL have port count, output, clog2(FIFO_DEPTH)+1, current FIFO fill level.
REQ-010 SHALL have port overflow, output, 1, sticky flag, write attempted while full.
REQ-011 SHALL have port TXD, output, 1, serial line, idle high, registered.

Function
REQ-012 SHALL accept a push when wr_en=1 and full=0, storing wr_data at the write pointer.
REQ-013 SHALL drop a write when wr_en=1 and full=1, leave FIFO contents unchanged, and set overflow=1 on the next edge.
REQ-014 SHALL evaluate full from the registered count; a push is rejected while full even if a pop occurs in the same cycle.
REQ-015 SHALL keep count unchanged on a simultaneous accepted push and pop; +1 on push only; -1 on pop only.
REQ-016 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-017 SHALL implement an FSM with states IDLE, START, DATA, STOP.
REQ-018 IDLE: TXD=1; if count!=0, pop the head byte into an 8-bit shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
REQ-019 START: TXD=0 for CLKS_PER_BIT cycles; at baud counter 0, reload it, clear the bit index, and go to DATA.
REQ-020 DATA: TXD=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit; at baud counter 0, shift right and increment the bit index; after bit index 7 go to STOP.
REQ-021 STOP: TXD=1 for CLKS_PER_BIT cycles; at baud counter 0, if count!=0, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-022 SHALL make each frame exactly 10*CLKS_PER_BIT cycles (8N1).
REQ-023 SHALL make TXD fall 2 edges after the edge sampling wr_en when writing to an empty FIFO in IDLE.
REQ-024 SHALL drive busy = (count!=0) or (state!=IDLE).
REQ-025 SHALL not let a push during a frame affect the byte being shifted.

Reset
REQ-026 While reset=1 at posedge SHALL: state=IDLE, TXD=1, count=0, pointers=0, full=0, busy=0, overflow=0, baud counter=0, bit index=0.
REQ-027 Reset SHALL override wr_en in the same cycle; no push occurs.
REQ-028 Reset mid-frame SHALL abort the frame; TXD=1 from the next edge and queued bytes are discarded.
REQ-029 FIFO storage SHALL need no reset; only pointers and count are reset.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-030 Single byte: write 0x55 from idle -> after 2 edges TXD = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; then busy=0 and TXD=1.
REQ-031 Back-to-back frames: write 0xA5 then 0x3C on consecutive cycles -> two 40-cycle frames with no idle cycle between the stop bit and the second start bit; data LSB first.
REQ-032 Full/overflow: 10 writes on consecutive cycles from idle -> writes 1-9 accepted, count=8 and full=1 after the 9th, 10th dropped, overflow=1 and sticky; 9 frames transmitted in order.
REQ-033 Simultaneous push/pop: push on the exact cycle STOP pops -> count unchanged, both bytes transmitted in order.
REQ-034 Reset mid-frame: assert reset during DATA bit 3 with 3 bytes queued -> next edge TXD=1, count=0, busy=0, overflow=0; no further frames.
REQ-035 Wrap-around: 20 bytes written in bursts of 4 with gaps -> all 20 received intact by a bench UART model, with no pointer corruption.
